// File: rtl/op_loader.sv
// op_loader: host-side initiator for the CPU program RAM write port.
// Receives a framed byte stream (SYNC, LEN, LEN opcode bytes, CSUM),
// writes each opcode into opram at sequential addresses starting at
// BASE_ADDR and checks the 8-bit additive checksum. The CPU is held
// (cpu_hold=1) until a frame with a good checksum has fully landed.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   in_valid   stream byte valid
//   in_data    stream byte
//   in_ready   loader can accept a byte (always 1 out of reset)
//   write      opram write strobe, one cycle per opcode
//   writeop    opcode to write
//   writeaddr  opram address
//   cpu_hold   1 = CPU must stay in reset/idle
//   done       last frame loaded with good checksum
//   err        last frame failed (checksum or timeout)
module op_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter logic [7:0] SYNC      = 8'hA5,
  parameter int         TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       write,
  output logic [7:0] writeop,
  output logic [7:0] writeaddr,
  output logic       cpu_hold,
  output logic       done,
  output logic       err
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t          r_state;
  logic [8:0]      r_idx;
  logic [8:0]      r_cnt;
  logic [7:0]      r_sum;
  logic [TW-1:0]   r_timer;
  logic            r_write;
  logic [7:0]      r_op;
  logic [7:0]      r_addr;
  logic            r_hold;
  logic            r_done;
  logic            r_err;

  logic            w_acc;
  logic            w_tmo;

  // The loader never stalls; ready simply follows reset release.
  assign in_ready = rst;
  assign w_acc    = in_valid & in_ready;
  // Timer is about to reach TIMEOUT on this idle cycle.
  assign w_tmo    = (r_timer == TW'(TIMEOUT - 1));

  assign write     = r_write;
  assign writeop   = r_op;
  assign writeaddr = r_addr;
  assign cpu_hold  = r_hold;
  assign done      = r_done;
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_timer <= '0;
      r_write <= 1'b0;
      r_op    <= '0;
      r_addr  <= BASE_ADDR;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_write <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          // Only SYNC opens a frame; everything else is line noise.
          if (w_acc && in_data == SYNC) begin
            r_state <= S_LEN;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_timer <= '0;
          end
        end
        default: begin
          if (w_acc) begin
            r_timer <= '0;
            case (r_state)
              S_LEN: begin
                // LEN of zero encodes a full 256-opcode frame.
                r_cnt   <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                r_state <= S_DATA;
              end
              S_DATA: begin
                r_write <= 1'b1;
                r_op    <= in_data;
                r_addr  <= BASE_ADDR + r_idx[7:0];
                r_idx   <= r_idx + 9'd1;
                r_sum   <= r_sum + in_data;
                if (r_idx + 9'd1 == r_cnt) r_state <= S_CSUM;
              end
              default: begin
                if (in_data == r_sum) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_hold  <= 1'b0;
                end else begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                  r_hold  <= 1'b1;
                end
              end
            endcase
          end else if (w_tmo) begin
            // Stalled sender: abandon the frame, keep writes already made.
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_hold  <= 1'b1;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_op_loader.sv
module tb_op_loader;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int T0 = 1024;
  localparam int T1 = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic rdy0, wr0, hold0, done0, err0;
  logic [7:0] op0, ad0;
  logic rdy1, wr1, hold1, done1, err1;
  logic [7:0] op1, ad1;

  op_loader #(.BASE_ADDR(8'h00), .SYNC(SYNC), .TIMEOUT(T0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .write(wr0), .writeop(op0), .writeaddr(ad0),
    .cpu_hold(hold0), .done(done0), .err(err0));

  op_loader #(.BASE_ADDR(8'hF0), .SYNC(SYNC), .TIMEOUT(T1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .write(wr1), .writeop(op1), .writeaddr(ad1),
    .cpu_hold(hold1), .done(done1), .err(err1));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- reference model (one per DUT) ----------------
  int base [2] = '{0, 240};
  int tmo  [2] = '{T0, T1};
  int ph   [2];   // 0 waiting for SYNC, 1 want LEN, 2 payload, 3 want CSUM
  int idx  [2];
  int need [2];
  int acc  [2];
  int tmr  [2];
  logic       e_wr [2];
  logic [7:0] e_op [2];
  logic [7:0] e_ad [2];
  logic       e_hold [2];
  logic       e_done [2];
  logic       e_err  [2];

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        ph[k] = 0; idx[k] = 0; need[k] = 0; acc[k] = 0; tmr[k] = 0;
        e_wr[k] = 1'b0; e_op[k] = 8'h00; e_ad[k] = 8'(base[k]);
        e_hold[k] = 1'b1; e_done[k] = 1'b0; e_err[k] = 1'b0;
      end else begin
        e_wr[k] = 1'b0;
        if (ph[k] == 0) begin
          if (in_valid && in_data == SYNC) begin
            ph[k] = 1; idx[k] = 0; acc[k] = 0; tmr[k] = 0;
            e_hold[k] = 1'b1; e_done[k] = 1'b0; e_err[k] = 1'b0;
          end
        end else if (in_valid) begin
          tmr[k] = 0;
          if (ph[k] == 1) begin
            need[k] = (in_data == 8'h00) ? 256 : int'(in_data);
            ph[k] = 2;
          end else if (ph[k] == 2) begin
            e_wr[k] = 1'b1;
            e_op[k] = in_data;
            e_ad[k] = 8'((base[k] + idx[k]) % 256);
            idx[k]++;
            acc[k] += int'(in_data);
            if (idx[k] == need[k]) ph[k] = 3;
          end else begin
            if (int'(in_data) == acc[k] % 256) begin
              e_done[k] = 1'b1; e_hold[k] = 1'b0;
            end else begin
              e_err[k] = 1'b1; e_hold[k] = 1'b1;
            end
            ph[k] = 0;
          end
        end else begin
          tmr[k]++;
          if (tmr[k] >= tmo[k]) begin
            e_err[k] = 1'b1; e_hold[k] = 1'b1; ph[k] = 0; tmr[k] = 0;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic       a_rdy [2];
  logic       a_wr  [2];
  logic [7:0] a_op  [2];
  logic [7:0] a_ad  [2];
  logic       a_hold[2];
  logic       a_done[2];
  logic       a_err [2];
  assign a_rdy[0] = rdy0;  assign a_rdy[1] = rdy1;
  assign a_wr[0]  = wr0;   assign a_wr[1]  = wr1;
  assign a_op[0]  = op0;   assign a_op[1]  = op1;
  assign a_ad[0]  = ad0;   assign a_ad[1]  = ad1;
  assign a_hold[0] = hold0; assign a_hold[1] = hold1;
  assign a_done[0] = done0; assign a_done[1] = done1;
  assign a_err[0]  = err0;  assign a_err[1]  = err1;

  logic [15:0] wl0[$];
  logic [15:0] wl1[$];
  int          wc0[$];

  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[dut%0d] cyc=%0d: got %0h want %0h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        chk("in_ready", k, {7'd0, a_rdy[k]}, 8'd1);
        chk("write", k, {7'd0, a_wr[k]}, {7'd0, e_wr[k]});
        chk("writeop", k, a_op[k], e_op[k]);
        chk("writeaddr", k, a_ad[k], e_ad[k]);
        chk("cpu_hold", k, {7'd0, a_hold[k]}, {7'd0, e_hold[k]});
        chk("done", k, {7'd0, a_done[k]}, {7'd0, e_done[k]});
        chk("err", k, {7'd0, a_err[k]}, {7'd0, e_err[k]});
      end
      if (wr0) begin wl0.push_back({ad0, op0}); wc0.push_back(cyc); end
      if (wr1) wl1.push_back({ad1, op1});
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] pay [256];

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic frame(input int n, input int dlt, input int maxgap);
    int s;
    s = 0;
    send(SYNC);
    idle($urandom_range(maxgap, 0));
    send(8'(n));
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(maxgap, 0));
      send(pay[i]);
      s += int'(pay[i]);
    end
    idle($urandom_range(maxgap, 0));
    send(8'(s + dlt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int s0, s1, n, dlt, mg;
    logic [7:0] g;
    logic [15:0] e;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    lit("rst write", {15'd0, wr0}, 16'd0);
    lit("rst addr0", {8'd0, ad0}, 16'h0000);
    lit("rst addr1", {8'd0, ad1}, 16'h00F0);
    lit("rst op0", {8'd0, op0}, 16'h0000);
    lit("rst hold", {15'd0, hold0}, 16'd1);
    lit("rst done/err", {14'd0, done0, err0}, 16'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: good 3-byte frame, back to back
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    s0 = wl0.size();
    frame(3, 0, 0);
    idle(2);
    lit("t1 nwr", 16'(wl0.size() - s0), 16'd3);
    if (wl0.size() >= s0 + 3) begin
      lit("t1 w0", wl0[s0], 16'h0011);
      lit("t1 w1", wl0[s0+1], 16'h0122);
      lit("t1 w2", wl0[s0+2], 16'h0233);
      lit("t1 back2back", 16'(wc0[s0+2] - wc0[s0]), 16'd2);
    end
    lit("t1 done/hold/err", {13'd0, done0, hold0, err0}, 16'b100);

    // 2: bad checksum (67)
    s0 = wl0.size();
    frame(3, 1, 0);
    idle(2);
    lit("t2 nwr", 16'(wl0.size() - s0), 16'd3);
    lit("t2 done/hold/err", {13'd0, done0, hold0, err0}, 16'b011);

    // 3: 256-byte frame, address wrap on the F0 instance
    for (int i = 0; i < 256; i++) pay[i] = 8'(i);
    s1 = wl1.size();
    frame(256, 0, 0);
    idle(2);
    lit("t3 nwr", 16'(wl1.size() - s1), 16'd256);
    if (wl1.size() >= s1 + 256) begin
      lit("t3 first", wl1[s1], 16'hF000);
      lit("t3 FF", wl1[s1+15], 16'hFF0F);
      lit("t3 wrap", wl1[s1+16], 16'h0010);
      lit("t3 last", wl1[s1+255], 16'hEFFF);
    end
    lit("t3 done", {15'd0, done1}, 16'd1);

    // 4: timeout mid-frame, then recovery
    s0 = wl0.size();
    send(SYNC); send(8'h02); send(8'h10);
    idle(T0 - 1);
    lit("t4 err before", {15'd0, err0}, 16'd0);
    idle(1);
    lit("t4 err at tmo", {14'd0, err0, hold0}, 16'b11);
    lit("t4 nwr", 16'(wl0.size() - s0), 16'd1);
    if (wl0.size() > s0) lit("t4 w0", wl0[s0], 16'h0010);
    lit("t4 err1", {15'd0, err1}, 16'd1);
    pay[0] = 8'h5A;
    frame(1, 0, 0);
    idle(2);
    lit("t4 recover", {12'd0, done0, err0, done1, hold0}, 16'b1010);

    // 5: garbage before SYNC, gappy frame
    s0 = wl0.size();
    send(8'h00); send(8'hFF); send(8'hA4);
    idle(2);
    lit("t5 garbage nwr", 16'(wl0.size() - s0), 16'd0);
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    frame(8, 0, 5);
    idle(2);
    lit("t5 nwr", 16'(wl0.size() - s0), 16'd8);
    lit("t5 done", {14'd0, done0, done1}, 16'b11);

    // 6: reset while a write pulse is high
    send(SYNC); send(8'h04); send(8'h01); send(8'h02);
    lit("t6 pulse", {15'd0, wr0}, 16'd1);
    #1 rst = 1'b0;
    #1;
    lit("t6 write drop", {14'd0, wr0, wr1}, 16'd0);
    lit("t6 addr", {ad0, ad1}, 16'h00F0);
    lit("t6 op", {8'd0, op0}, 16'h0000);
    lit("t6 flags", {13'd0, hold0, done0, err0}, 16'b100);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    s0 = wl0.size();
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    frame(4, 0, 0);
    idle(2);
    lit("t6 nwr", 16'(wl0.size() - s0), 16'd4);
    if (wl0.size() >= s0 + 4) begin
      e = wl0[s0];   lit("t6 addr first", {8'd0, e[15:8]}, 16'h0000);
      e = wl0[s0+3]; lit("t6 addr last", {8'd0, e[15:8]}, 16'h0003);
    end
    lit("t6 done", {15'd0, done0}, 16'd1);

    // randomized frames against the model
    repeat (40) begin
      repeat ($urandom_range(2, 0)) begin
        g = 8'($urandom);
        if (g == SYNC) g = g ^ 8'h01;
        send(g);
      end
      n = ($urandom_range(9, 0) == 0) ? 256 : $urandom_range(40, 1);
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      dlt = ($urandom_range(3, 0) == 0) ? $urandom_range(255, 1) : 0;
      mg = ($urandom_range(7, 0) == 0) ? 20 : 3;
      frame(n, dlt, mg);
      idle($urandom_range(3, 0));
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
